split2_route_cache: RTL and testbench
=====================================

Name: split2_route_cache

Overview:
- Clocked 1-to-2 routing split for the cache control path. It is the fan-out counterpart of the two-input arbitrated merge that feeds the same drive/free channel.
- Accepts one token (drive pulse plus data) from a single upstream channel and forwards it to output 0 or output 1, selected by a route bit inside the data word.
- Each output has a one-entry holding slot. A busy output stalls only tokens routed to it.

Parameters:
DATA_WIDTH, 5, width of token data, identical on input and both outputs.
ROUTE_BIT, DATA_WIDTH-1, index of the data bit that selects the destination (0 -> output 0, 1 -> output 1).

Ports:
clk  input  1  single clock; all state changes on the rising edge.
rstn  input  1  reset, asynchronous, active-low.
i_drive  input  1  upstream token-valid pulse, one cycle wide.
i_data  input  DATA_WIDTH  token data, sampled in the i_drive cycle.
o_free  output  1  one-cycle pulse: input buffer released, upstream may send the next token.
o_drive0  output  1  one-cycle pulse: new token on o_data0.
o_data0  output  DATA_WIDTH  output 0 data, stable from o_drive0 until i_free0.
i_free0  input  1  one-cycle pulse: consumer 0 has taken its token.
o_drive1  output  1  one-cycle pulse: new token on o_data1.
o_data1  output  DATA_WIDTH  output 1 data, stable from o_drive1 until i_free1.
i_free1  input  1  one-cycle pulse: consumer 1 has taken its token.
o_overrun  output  1  sticky flag: a protocol violation was detected.

Behaviour:
- Reset:
  - Asynchronous assert clears all state.
  - All outputs are 0: o_free, o_drive0/1, o_data0/1, o_overrun.
  - Input buffer is EMPTY and both slots are IDLE.
  - Any token in flight is discarded. No o_free pulse is issued after reset.
  - Upstream may send its first token without waiting for a free pulse.
- Input buffer FSM, states EMPTY and FULL:
  - EMPTY + i_drive: capture i_data into r_in, go to FULL.
  - FULL + transfer condition: go to EMPTY.
  - FULL + i_drive: protocol violation. The token is dropped, o_overrun is set, r_in is unchanged.
- Output slot k FSM, per output, states IDLE and BUSY:
  - Transfer condition for slot k: input is FULL, r_in[ROUTE_BIT]==k, and slot k is IDLE in registered state.
  - On transfer: r_data_k <= r_in, slot k goes BUSY, and o_drive_k and o_free are both registered high for exactly one cycle.
  - BUSY + i_free_k: go to IDLE at that edge. The next transfer into k happens at the following edge at the earliest (no same-cycle free/transfer bypass).
  - IDLE + i_free_k: spurious free. Ignored, and o_overrun is set.
- Latency:
  - i_drive in cycle t, route slot idle: o_drive_k and o_free high in cycle t+2.
  - Blocked token: o_drive_k and o_free occur 2 cycles after the i_free_k pulse.
- Blocking:
  - A token whose slot is BUSY holds the input FULL. o_free is withheld, so upstream stalls.
  - The other output is unaffected and keeps accepting its own i_free.
- Simultaneous events:
  - i_free0 and i_free1 in the same cycle are both honoured.
  - i_drive in the same cycle as a transfer out of FULL is an overrun, because upstream must wait for o_free.
- Data hold: o_data_k changes only on a transfer into slot k and otherwise holds its last value, including after i_free_k.
- o_overrun is cleared only by rstn.

Optional Feature:
- Macro: SPLIT_BYPASS_EN.
- When defined:
  - i_drive with input EMPTY and the routed slot IDLE transfers directly at that edge.
  - r_data_k <= i_data, and o_drive_k and o_free pulse in cycle t+1. The input stays EMPTY.
  - All other cases behave as in the base description.
- When undefined: every token passes through r_in, with a minimum latency of 2 cycles.

Test Plan:
- Reset then i_drive with i_data=5'b00011 (route 0): o_drive0 and o_free pulse at t+2, o_data0=5'b00011, o_drive1 stays 0.
- Two tokens alternating: 5'b10110 then 5'b00001 (next drive after o_free): o_data1=5'b10110 and o_data0=5'b00001, each with exactly one drive pulse and no overrun.
- Back-to-back to output 0 without i_free0: second token 5'b00101 held, no o_free. Pulse i_free0 at cycle c: o_drive0 at c+2, o_data0=5'b00101.
- Output 1 busy while a token routed to 0 arrives: token to 0 completes normally. Same-cycle i_free0 and i_free1 both return their slots to IDLE.
- i_drive while input FULL, and i_free1 while slot 1 IDLE: o_overrun=1 and sticky, r_in and the slots unchanged. Assert rstn=0 mid-stall: all outputs 0 immediately, o_overrun cleared.
- With SPLIT_BYPASS_EN: idle system, i_drive with data 5'b10000: o_drive1 and o_free at t+1. With a busy slot, latency falls back to the base path.

Source files
------------

// File: rtl/split2_route_cache.sv
// split2_route_cache: clocked 1-to-2 routing split; a route bit in the token picks output 0 or 1
//   clk, rstn (async active-low)
//   i_drive/i_data -> token in;  o_free -> upstream may send next token
//   o_drive0/o_data0, i_free0 -> output 0 slot;  o_drive1/o_data1, i_free1 -> output 1 slot
//   o_overrun -> sticky protocol-violation flag
//   SPLIT_BYPASS_EN: when defined, a token hitting an empty input and idle slot skips r_in
module split2_route_cache #(
  parameter int DATA_WIDTH = 5,
  parameter int ROUTE_BIT = DATA_WIDTH - 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_drive,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_free,
  output logic                  o_drive0,
  output logic [DATA_WIDTH-1:0] o_data0,
  input  logic                  i_free0,
  output logic                  o_drive1,
  output logic [DATA_WIDTH-1:0] o_data1,
  input  logic                  i_free1,
  output logic                  o_overrun
);
  typedef enum logic {EMPTY, FULL} in_state_t;
  typedef enum logic {IDLE, BUSY} slot_state_t;
  in_state_t in_state;
  slot_state_t slot0, slot1;
  logic [DATA_WIDTH-1:0] r_in;
  logic xfer0, xfer1, byp0, byp1;
  // Slot state is the registered one, so a free and a refill never share an edge.
  assign xfer0 = in_state == FULL && !r_in[ROUTE_BIT] && slot0 == IDLE;
  assign xfer1 = in_state == FULL && r_in[ROUTE_BIT] && slot1 == IDLE;
`ifdef SPLIT_BYPASS_EN
  assign byp0 = in_state == EMPTY && i_drive && !i_data[ROUTE_BIT] && slot0 == IDLE;
  assign byp1 = in_state == EMPTY && i_drive && i_data[ROUTE_BIT] && slot1 == IDLE;
`else
  assign byp0 = 1'b0;
  assign byp1 = 1'b0;
`endif
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_state  <= EMPTY;
      slot0     <= IDLE;
      slot1     <= IDLE;
      r_in      <= '0;
      o_free    <= 1'b0;
      o_drive0  <= 1'b0;
      o_drive1  <= 1'b0;
      o_data0   <= '0;
      o_data1   <= '0;
      o_overrun <= 1'b0;
    end else begin
      o_drive0 <= xfer0 | byp0;
      o_drive1 <= xfer1 | byp1;
      o_free   <= xfer0 | xfer1 | byp0 | byp1;
      if (xfer0) o_data0 <= r_in;
      else if (byp0) o_data0 <= i_data;
      if (xfer1) o_data1 <= r_in;
      else if (byp1) o_data1 <= i_data;
      slot0 <= (xfer0 | byp0) ? BUSY : i_free0 ? IDLE : slot0;
      slot1 <= (xfer1 | byp1) ? BUSY : i_free1 ? IDLE : slot1;
      if (in_state == EMPTY && i_drive) r_in <= i_data;
      in_state <= in_state == FULL ? ((xfer0 | xfer1) ? EMPTY : FULL)
                                   : ((i_drive && !byp0 && !byp1) ? FULL : EMPTY);
      // A drive while FULL (even in the cycle it drains) is dropped: upstream must wait for o_free.
      o_overrun <= o_overrun | (in_state == FULL && i_drive)
                             | (slot0 == IDLE && i_free0) | (slot1 == IDLE && i_free1);
    end
  end
endmodule

// File: tb/tb_split2_route_cache.sv
// tb_split2_route_cache: scoreboard bench for split2_route_cache; expected drives/frees are queued
// at stimulus time with their cycle, and a negedge monitor pops and compares each DUT pulse.
module tb_split2_route_cache;
`ifdef SPLIT_BYPASS_EN
  localparam int L = 1;
`else
  localparam int L = 2;
`endif
  typedef struct {logic [4:0] d; int at;} exp_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic i_drive = 1'b0, i_free0 = 1'b0, i_free1 = 1'b0;
  logic [4:0] i_data = '0;
  logic o_free, o_drive0, o_drive1, o_overrun;
  logic [4:0] o_data0, o_data1;
  int cyc = 0, pass = 0, total = 0, t, c;
  exp_t q0[$], q1[$];
  int qf[$];
  split2_route_cache dut (
    .clk(clk), .rstn(rstn), .i_drive(i_drive), .i_data(i_data), .o_free(o_free),
    .o_drive0(o_drive0), .o_data0(o_data0), .i_free0(i_free0),
    .o_drive1(o_drive1), .o_data1(o_data1), .i_free1(i_free1), .o_overrun(o_overrun)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
  endtask
  task automatic unexpected(input string n);
    total++;
    $display("FAIL %s: got unexpected pulse expected none (cycle %0d)", n, cyc);
  endtask
  always @(negedge clk) if (rstn) begin
    exp_t e;
    int f;
    if (o_drive0) begin
      if (q0.size() == 0) unexpected("drive0");
      else begin
        e = q0.pop_front();
        check("data0", o_data0, e.d);
        check("drive0 cycle", cyc, e.at);
      end
    end
    if (o_drive1) begin
      if (q1.size() == 0) unexpected("drive1");
      else begin
        e = q1.pop_front();
        check("data1", o_data1, e.d);
        check("drive1 cycle", cyc, e.at);
      end
    end
    if (o_free) begin
      if (qf.size() == 0) unexpected("free");
      else begin
        f = qf.pop_front();
        check("free cycle", cyc, f);
      end
    end
  end
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic drive(input logic [4:0] d);
    i_drive = 1'b1;
    i_data = d;
    @(negedge clk);
    i_drive = 1'b0;
  endtask
  task automatic frees(input logic f0, input logic f1);
    i_free0 = f0;
    i_free1 = f1;
    @(negedge clk);
    i_free0 = 1'b0;
    i_free1 = 1'b0;
  endtask
  task automatic exp_out(input int k, input logic [4:0] d, input int at);
    exp_t e;
    e.d = d;
    e.at = at;
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
    qf.push_back(at);
  endtask
  task automatic check_zero(input string n);
    check({n, " free"}, o_free, 0);
    check({n, " drive0"}, o_drive0, 0);
    check({n, " drive1"}, o_drive1, 0);
    check({n, " data0"}, o_data0, 0);
    check({n, " data1"}, o_data1, 0);
    check({n, " overrun"}, o_overrun, 0);
  endtask
  task automatic async_reset(input string n);
    #2 rstn = 1'b0;
    #1 check_zero(n);
    q0.delete();
    q1.delete();
    qf.delete();
    @(negedge clk);
    rstn = 1'b1;
    step(1);
  endtask
  initial begin
    step(2);
    check_zero("reset");
    rstn = 1'b1;
    step(1);
    // single token to output 0
    t = cyc; exp_out(0, 5'b00011, t + L); drive(5'b00011);
    step(2);
    frees(1, 0);
    check("hold0 after free", o_data0, 5'b00011);
    // alternating outputs, then simultaneous frees
    t = cyc; exp_out(1, 5'b10110, t + L); drive(5'b10110);
    step(L);
    t = cyc; exp_out(0, 5'b00001, t + L); drive(5'b00001);
    step(2);
    frees(1, 1);
    check("overrun alt", o_overrun, 0);
    // back-to-back to output 0: second token waits for i_free0
    t = cyc; exp_out(0, 5'b00100, t + L); drive(5'b00100);
    step(L);
    drive(5'b00101);
    step(3);
    c = cyc; exp_out(0, 5'b00101, c + 2); frees(1, 0);
    step(3);
    check("blocked data0", o_data0, 5'b00101);
    frees(1, 0);
    check("overrun b2b", o_overrun, 0);
    // output 1 busy while token to 0 flows; same-cycle frees release both
    t = cyc; exp_out(1, 5'b11000, t + L); drive(5'b11000);
    step(L);
    t = cyc; exp_out(0, 5'b01010, t + L); drive(5'b01010);
    step(2);
    frees(1, 1);
    t = cyc; exp_out(0, 5'b00111, t + L); drive(5'b00111);
    step(L);
    t = cyc; exp_out(1, 5'b10111, t + L); drive(5'b10111);
    step(2);
    frees(1, 1);
    check("overrun both", o_overrun, 0);
    // spurious free on idle slot 1
    frees(0, 1);
    check("overrun spurious", o_overrun, 1);
    check("data1 kept", o_data1, 5'b10111);
    step(2);
    check("overrun sticky", o_overrun, 1);
    async_reset("reset1");
    // drive while input FULL: dropped, r_in kept
    t = cyc; exp_out(1, 5'b10001, t + L); drive(5'b10001);
    step(L);
    drive(5'b10010);
    drive(5'b01111);
    check("overrun full", o_overrun, 1);
    step(2);
    c = cyc; exp_out(1, 5'b10010, c + 2); frees(0, 1);
    step(3);
    frees(0, 1);
    check("overrun held", o_overrun, 1);
    check("data0 untouched", o_data0, 0);
    // reset in the middle of a stall
    t = cyc; exp_out(0, 5'b01100, t + L); drive(5'b01100);
    step(L);
    drive(5'b01101);
    step(2);
    check("stall data0", o_data0, 5'b01100);
    async_reset("reset2");
    // first token after reset needs no free pulse
    t = cyc; exp_out(1, 5'b10011, t + L); drive(5'b10011);
    step(3);
    frees(0, 1);
    check("q0 drained", q0.size(), 0);
    check("q1 drained", q1.size(), 0);
    check("qf drained", qf.size(), 0);
    check("final overrun", o_overrun, 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
